// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block: loader state encoding, default geometry and
// an index-width helper.
package pwm_pkg;

  localparam int unsigned PwmWidth = 8;
  localparam int unsigned PwmSize  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StPending
  } pwm_state_e;

  // Index width for an n-entry bank; a single-entry bank still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_shadow_bank.sv
// SIZE x WIDTH shadow register array written one word at a time, copied in parallel
// to the active bank on commit.
module pwm_shadow_bank
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidth,
  parameter int unsigned SIZE  = PwmSize,
  parameter int unsigned IDXW  = idx_width(SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [IDXW-1:0]       i_wr_idx,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_commit,
  output logic [SIZE*WIDTH-1:0] o_active
);

  logic [WIDTH-1:0]      r_shadow [SIZE];
  logic [SIZE*WIDTH-1:0] r_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(SIZE); k++) begin
        r_shadow[k] <= '0;
      end
    end else if (i_wr_en) begin
      r_shadow[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= '0;
    end else if (i_commit) begin
      for (int k = 0; k < int'(SIZE); k++) begin
        r_active[k*WIDTH +: WIDTH] <= r_shadow[k];
      end
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/pwm_duty_loader.sv
// Framed duty-word loader: fills a shadow bank, then commits it to the active PWM bank
// only on a period wrap so every channel switches cleanly between whole frames.
module pwm_duty_loader
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidth,
  parameter int unsigned SIZE  = PwmSize
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_din,
  input  logic                  i_din_valid,
  input  logic                  i_din_sof,
  output logic                  o_din_ready,
  input  logic                  i_period_wrap,
  output logic [SIZE*WIDTH-1:0] o_duty_out,
  output logic                  o_pending,
  output logic                  o_update_pulse,
  output logic                  o_frame_err
);

  localparam int unsigned      IdxW      = idx_width(SIZE);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(SIZE - 1);
  // After word 0 a single-entry frame is already complete.
  localparam logic [IdxW-1:0]  SecondIdx = IdxW'((SIZE > 1) ? 1 : 0);
  localparam pwm_state_e       AfterSof  = (SIZE > 1) ? StFill : StPending;

  pwm_state_e       r_state, w_state_next;
  logic [IdxW-1:0]  r_idx, w_idx_next;
  logic             r_update_pulse, w_update_next;
  logic             r_frame_err, w_frame_err_next;
  logic             w_xfer;
  logic             w_wr_en;
  logic [IdxW-1:0]  w_wr_idx;
  logic             w_commit;

  assign o_din_ready = (r_state != StPending);
  assign o_pending   = (r_state == StPending);
  assign w_xfer      = i_din_valid && o_din_ready;

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_update_next    = 1'b0;
    w_frame_err_next = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_idx         = '0;
    w_commit         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          if (i_din_sof) begin
            w_wr_en      = 1'b1;
            w_idx_next   = SecondIdx;
            w_state_next = AfterSof;
          end else begin
            w_frame_err_next = 1'b1;
          end
        end
      end
      StFill: begin
        if (w_xfer) begin
          w_wr_en = 1'b1;
          if (i_din_sof) begin
            // Restart the frame at word 0; stale words get rewritten before commit.
            w_idx_next       = SecondIdx;
            w_state_next     = AfterSof;
            w_frame_err_next = 1'b1;
          end else begin
            w_wr_idx = r_idx;
            if (r_idx == LastIdx) begin
              w_idx_next   = '0;
              w_state_next = StPending;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
        end
      end
      StPending: begin
        if (i_period_wrap) begin
          w_commit      = 1'b1;
          w_update_next = 1'b1;
          w_idx_next    = '0;
          w_state_next  = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_idx          <= '0;
      r_update_pulse <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_idx_next;
      r_update_pulse <= w_update_next;
      r_frame_err    <= w_frame_err_next;
    end
  end

  assign o_update_pulse = r_update_pulse;
  assign o_frame_err    = r_frame_err;

  pwm_shadow_bank #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .IDXW  (IdxW)
  ) u_shadow_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (i_din),
    .i_commit  (w_commit),
    .o_active  (o_duty_out)
  );

endmodule

// File: tb/tb_pwm_duty_loader.sv
// Scoreboard bench for pwm_duty_loader: a frame-level model queues expected commits and
// frame errors; a monitor pops and compares them when the DUT pulses its outputs.
module tb_pwm_duty_loader;

  localparam int W = 8;
  localparam int S = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     din = '0;
  logic             din_valid = 1'b0;
  logic             din_sof = 1'b0;
  logic             period_wrap = 1'b0;
  logic             din_ready;
  logic [S*W-1:0]   duty_out;
  logic             pending;
  logic             update_pulse;
  logic             frame_err;

  // Single-channel build.
  logic [W-1:0]     d1_din = '0;
  logic             d1_valid = 1'b0;
  logic             d1_sof = 1'b0;
  logic             d1_wrap = 1'b0;
  logic             d1_ready;
  logic [W-1:0]     d1_duty;
  logic             d1_pending;
  logic             d1_update;
  logic             d1_err;

  always #5 clk = ~clk;

  pwm_duty_loader #(.WIDTH(W), .SIZE(S)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_din          (din),
    .i_din_valid    (din_valid),
    .i_din_sof      (din_sof),
    .o_din_ready    (din_ready),
    .i_period_wrap  (period_wrap),
    .o_duty_out     (duty_out),
    .o_pending      (pending),
    .o_update_pulse (update_pulse),
    .o_frame_err    (frame_err)
  );

  pwm_duty_loader #(.WIDTH(W), .SIZE(1)) dut1 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_din          (d1_din),
    .i_din_valid    (d1_valid),
    .i_din_sof      (d1_sof),
    .o_din_ready    (d1_ready),
    .i_period_wrap  (d1_wrap),
    .o_duty_out     (d1_duty),
    .o_pending      (d1_pending),
    .o_update_pulse (d1_update),
    .o_frame_err    (d1_err)
  );

  typedef struct {
    int             edge_no;
    logic [S*W-1:0] bank;
  } commit_t;

  int             checks = 0;
  int             failures = 0;
  int             edge_cnt = 0;
  commit_t        cq[$];
  int             eq[$];
  logic [S*W-1:0] cur_bank = '0;

  // Frame-level model state.
  logic [W-1:0]   m_frame[$];
  bit             m_pend = 1'b0;
  logic [S*W-1:0] m_bank = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at edge %0d", name, edge_cnt);
  endtask

  // Drive one cycle; the model predicts what the coming edge does.
  task automatic step(input bit v, input bit sof, input logic [W-1:0] d, input bit wrap);
    int  tgt;
    bit  was_pend;
    commit_t c;
    @(negedge clk);
    if (rst_n) begin
      chk("din_ready", {63'd0, din_ready}, {63'd0, !m_pend});
      chk("pending", {63'd0, pending}, {63'd0, m_pend});
    end else begin
      chk("rst_duty", duty_out, '0);
      chk("rst_ready", {63'd0, din_ready}, 64'd1);
      chk("rst_pending", {63'd0, pending}, 64'd0);
    end
    din_valid   = v;
    din_sof     = sof;
    din         = d;
    period_wrap = wrap;
    if (rst_n) begin
      tgt      = edge_cnt + 1;
      was_pend = m_pend;
      if (was_pend && wrap) begin
        c.edge_no = tgt;
        c.bank    = m_bank;
        cq.push_back(c);
        m_pend = 1'b0;
        m_frame.delete();
      end
      if (v && !was_pend) begin
        if (sof) begin
          if (m_frame.size() != 0) eq.push_back(tgt);
          m_frame.delete();
          m_frame.push_back(d);
        end else if (m_frame.size() == 0) begin
          eq.push_back(tgt);
        end else begin
          m_frame.push_back(d);
        end
        if (m_frame.size() == S) begin
          m_pend = 1'b1;
          for (int k = 0; k < S; k++) m_bank[k*W +: W] = m_frame[k];
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit wrap_last);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, wrap_last && (i == n - 1));
  endtask

  task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] inc);
    logic [W-1:0] w;
    w = base;
    for (int k = 0; k < S; k++) begin
      step(1'b1, k == 0, w, 1'b0);
      w = w + inc;
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_frame.delete();
    cur_bank = '0;
    cq.delete();
    eq.delete();
  endtask

  // Monitor: compare outputs against queued expectations after every edge.
  initial begin
    commit_t c;
    int      e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (update_pulse) begin
          if (cq.size() == 0) begin
            fail_now("update_pulse_spurious");
          end else begin
            c = cq.pop_front();
            chk("commit_edge", 64'(edge_cnt), 64'(c.edge_no));
            cur_bank = c.bank;
          end
        end else if (cq.size() != 0 && cq[0].edge_no <= edge_cnt) begin
          fail_now("update_pulse_missing");
          c = cq.pop_front();
          cur_bank = c.bank;
        end
        chk("duty_out", duty_out, cur_bank);
        if (frame_err) begin
          if (eq.size() == 0) begin
            fail_now("frame_err_spurious");
          end else begin
            e = eq.pop_front();
            chk("frame_err_edge", 64'(edge_cnt), 64'(e));
          end
        end else if (eq.size() != 0 && eq[0] <= edge_cnt) begin
          fail_now("frame_err_missing");
          void'(eq.pop_front());
        end
      end
    end
  end

  initial begin
    // Traffic while reset is held must not disturb anything.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hAA, 1'b1);
    chk("d1_rst_duty", {56'd0, d1_duty}, 64'd0);
    @(negedge clk);
    din_valid = 1'b0;
    period_wrap = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Normal frame, wrap 20 cycles later.
    send_frame(8'h10, 8'h10);
    idle(20, 1'b1);
    idle(2, 1'b0);
    chk("normal_bank", duty_out, 64'h8070605040302010);

    // Back-pressure: 0xFF held through PENDING, accepted only after commit.
    send_frame(8'h31, 8'h01);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int k = 1; k < S; k++) step(1'b1, 1'b0, 8'(k), 1'b0);
    idle(3, 1'b1);
    idle(2, 1'b0);

    // Restart mid-frame.
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    send_frame(8'hA0, 8'h01);
    idle(2, 1'b1);
    idle(2, 1'b0);
    chk("restart_bank", duty_out, 64'hA7A6A5A4A3A2A1A0);

    // Orphan word, then a wrap coinciding with the last word.
    step(1'b1, 1'b0, 8'h55, 1'b0);
    for (int k = 0; k < S; k++) step(1'b1, k == 0, 8'(8'hC0 + k), k == S - 1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Asynchronous reset while a frame is pending.
    send_frame(8'hE0, 8'h01);
    idle(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty_out, '0);
    chk("async_rst_pending", {63'd0, pending}, 64'd0);
    chk("async_rst_ready", {63'd0, din_ready}, 64'd1);
    model_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 8'h5A, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    period_wrap = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 9) == 0);
    end
    idle(5, 1'b1);
    idle(4, 1'b0);
    chk("commit_queue_drained", 64'(cq.size()), 64'd0);
    chk("err_queue_drained", 64'(eq.size()), 64'd0);

    // Single-channel build.
    @(negedge clk);
    chk("d1_ready_idle", {63'd0, d1_ready}, 64'd1);
    chk("d1_pending_idle", {63'd0, d1_pending}, 64'd0);
    d1_valid = 1'b1;
    d1_sof   = 1'b1;
    d1_din   = 8'h7F;
    @(negedge clk);
    d1_valid = 1'b0;
    d1_sof   = 1'b0;
    chk("d1_pending", {63'd0, d1_pending}, 64'd1);
    chk("d1_ready_pend", {63'd0, d1_ready}, 64'd0);
    chk("d1_duty_pre", {56'd0, d1_duty}, 64'd0);
    d1_wrap = 1'b1;
    @(negedge clk);
    d1_wrap = 1'b0;
    chk("d1_duty_commit", {56'd0, d1_duty}, 64'h7F);
    chk("d1_update", {63'd0, d1_update}, 64'd1);
    chk("d1_pending_after", {63'd0, d1_pending}, 64'd0);
    chk("d1_ready_after", {63'd0, d1_ready}, 64'd1);
    @(negedge clk);
    chk("d1_update_one_cycle", {63'd0, d1_update}, 64'd0);
    chk("d1_no_err", {63'd0, d1_err}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_loader.md
# pwm_duty_loader

Upstream stage of the 8-channel PWM block: accepts a framed stream of duty-cycle words, assembles them in a shadow bank, and commits the full bank to the PWM comparators only on a PWM period boundary. Glitch-free duty updates: a channel never sees a mixed old/new set or a mid-period change. Sits between the input pins/host interface and the PWM counter/comparator stage.

## Interface
- `WIDTH`, 8, bits per duty word (and PWM counter width)
- `SIZE`, 8, number of PWM channels (words per frame), ≥1
- `clk` in 1: single system clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `din` in WIDTH: duty word
- `din_valid` in 1: `din` valid this cycle
- `din_sof` in 1: qualifies `din` as word 0 (channel 0) of a frame; meaningful only with `din_valid`
- `din_ready` out 1: loader accepts a word this cycle
- `period_wrap` in 1: one-cycle pulse from PWM counter, high in the cycle the counter wraps to 0
- `duty_out` out SIZE*WIDTH: active bank; channel k at `duty_out[k*WIDTH +: WIDTH]`
- `pending` out 1: complete frame waiting for `period_wrap`
- `update_pulse` out 1: one-cycle pulse, active bank just changed
- `frame_err` out 1: one-cycle pulse on protocol violation

## Operation
- Transfer occurs on a rising edge where `din_valid && din_ready`.
- States: IDLE, FILL, PENDING. `din_ready` = 1 in IDLE and FILL, 0 in PENDING.
- IDLE: transfer with `din_sof`=1 → shadow[0] ← din, idx ← 1, go FILL (SIZE=1: go PENDING). Transfer with `din_sof`=0 → word dropped, `frame_err` pulse, stay IDLE.
- FILL: transfer with `din_sof`=0 → shadow[idx] ← din, idx++; when idx was SIZE-1 go PENDING. Transfer with `din_sof`=1 → restart: shadow[0] ← din, idx ← 1, `frame_err` pulse, stay FILL (SIZE=1: PENDING).
- PENDING: no transfers. On `period_wrap`=1 → `duty_out` ← shadow, go IDLE, `update_pulse` next cycle.
- `period_wrap` outside PENDING: ignored. Wrap in the same cycle the last word transfers: not a commit; commit waits for the next wrap.
- Shadow words not yet rewritten in a restarted frame keep stale values but are always overwritten before PENDING (every frame writes all SIZE words).
- idx width: clog2(SIZE) (min 1 bit); never exceeds SIZE-1.
- No arithmetic on duty values; words passed bit-exact.

## Timing
- Reset (async assert, sync release on next edge): state IDLE, idx 0, shadow 0, `duty_out` 0, `pending` 0, `update_pulse` 0, `frame_err` 0, `din_ready` 1.
- All outputs registered except `din_ready` (decoded from state register, no combinational path from inputs).
- `pending` = 1 exactly while in PENDING.
- Commit latency: `duty_out` changes at the edge sampling `period_wrap`=1 in PENDING; `update_pulse` high the cycle after that edge, same cycle `din_ready` returns to 1.
- Min frame cost: SIZE cycles fill + wait for wrap + 1.
- `frame_err` high the cycle after the offending edge.
- Reset mid-frame or mid-PENDING: shadow and partial frame discarded, `duty_out` cleared to 0.

## Structure
- Shared package `pwm_pkg`: state enum (IDLE/FILL/PENDING), default `WIDTH`/`SIZE` constants, shared with the PWM stage.
- Sub-module `pwm_shadow_bank` (SIZE×WIDTH write-indexed register array plus parallel copy-to-active on commit); FSM and handshake in the top of this block.

## Test plan
- Reset: hold `rst_n`=0, drive traffic → `duty_out`=0, `din_ready`=1, `pending`=0; assert `rst_n`=0 async mid-PENDING → `duty_out` clears without a clock edge.
- Normal frame: send 0x10,0x20..0x80 (sof on first), wrap 20 cycles later → `pending` high from cycle after 8th word to commit; `duty_out` = {0x80,...,0x10}, `update_pulse` one cycle.
- Back-pressure: valid held during PENDING with 0xFF → no transfer, `duty_out` unchanged until wrap; 0xFF accepted as next frame only after commit.
- Restart: sof+0x11, 0x22, 0x33, then sof+0xA0..0xA7 → `frame_err` one pulse, committed bank = 0xA0..0xA7.
- Orphan word: non-sof 0x55 in IDLE → dropped, `frame_err` pulse, state IDLE; wrap in same cycle as 8th word → no commit, commit on following wrap.
- SIZE=1 build: single sof word 0x7F → immediate PENDING, commit on wrap.
